pd_sample_controller: RTL and testbench
=======================================

# pd_sample_controller

Sequencer for the delay-line phase detector. It runs repeated measurement cycles on the detector: clear it, wait out a measurement window, synchronise and debounce its asynchronous signed output into the fpga clock domain, then average a batch of samples. It hands the loop filter one clean, averaged error word per batch with a valid strobe, plus saturation and timeout status.

## Interface
- WIDTH, 5: detector output width, signed two's complement (sign + WIDTH-1 magnitude bits).
- RESET_CYCLES, 4: cycles pd_reset_o is held high per measurement (≥1).
- WINDOW_CYCLES, 16: cycles waited after clear release before sampling begins (≥1; must exceed one reference period).
- STABLE_CYCLES, 2: consecutive identical synchronised samples required to accept a value (≥1).
- TIMEOUT_CYCLES, 32: maximum cycles in CAPTURE before the sample is abandoned (> STABLE_CYCLES).
- LOG2_AVG, 2: batch size is 2^LOG2_AVG samples.

Ports:
- fpga_clk_i, in, 1: sole clock, rising edge.
- reset_i, in, 1: synchronous, active-high reset.
- enable_i, in, 1: run measurements while high.
- pd_error_i, in, WIDTH: detector output, asynchronous to fpga_clk_i, signed.
- pd_reset_o, out, 1: drives the detector's reset; high clears it.
- error_o, out, WIDTH: signed averaged error; holds its value between strobes.
- error_valid_o, out, 1: one-cycle strobe when error_o updates.
- saturated_o, out, 1: qualifies error_o; a sample in the batch hit full scale.
- timeout_o, out, 1: one-cycle strobe when a sample is abandoned.
- busy_o, out, 1: high whenever the state is not IDLE.

## Operation
- Synchronisation: pd_error_i passes through a 2-flop synchroniser per bit. Bus skew is handled by the stability check, not by Gray coding.
- States:
  - IDLE: pd_reset_o=1. Go to CLEAR when enable_i=1.
  - CLEAR: pd_reset_o=1 for exactly RESET_CYCLES cycles, then go to WAIT.
  - WAIT: pd_reset_o=0 for exactly WINDOW_CYCLES cycles, then go to CAPTURE.
  - CAPTURE: pd_reset_o=0. Each cycle, compare the synchronised sample with the previous cycle's.
    - Equal: increment the stable counter. Different: the counter restarts at 1.
    - When the counter reaches STABLE_CYCLES, the sample is accepted.
    - First cycle in CAPTURE counts as 1.
  - After acceptance: add the sample to the accumulator and increment the batch count. Go to OUTPUT if the batch is full, else to CLEAR.
  - OUTPUT: one cycle, then CLEAR.
- Timeout: TIMEOUT_CYCLES cycles in CAPTURE without acceptance pulses timeout_o and returns to CLEAR. Nothing is accumulated, and the batch count is unchanged.
- Accumulator:
  - Signed, WIDTH+LOG2_AVG bits, sign-extended adds; it cannot overflow.
  - error_o = accumulator >>> LOG2_AVG (arithmetic shift, floor toward −∞), truncated to WIDTH bits.
  - The accumulator and batch count clear on entry to OUTPUT's successor and on leaving IDLE.
- Saturation: a sample saturates if its magnitude is ≥ 2^(WIDTH-1)−1, i.e. +15, −15 or −16 at WIDTH=5.
  - A sticky per-batch flag records any saturating sample.
  - saturated_o is loaded from the flag in OUTPUT and held with error_o.
- enable_i low in any non-IDLE state: go to IDLE next cycle and discard the partial batch. error_o and saturated_o keep their last values.

## Timing
- Reset values: pd_reset_o=1, error_o=0, error_valid_o=0, saturated_o=0, timeout_o=0, busy_o=0, state IDLE, accumulator, counters and synchroniser all 0.
- reset_i overrides everything, including mid-batch and during OUTPUT; no strobe is emitted on that cycle.
- error_valid_o, error_o and saturated_o update on the same edge, the one leaving OUTPUT.
- pd_error_i change to first visibility at the comparator: 2 cycles.
- Minimum per-sample time: RESET_CYCLES + WINDOW_CYCLES + STABLE_CYCLES cycles, i.e. 22 at defaults with a constant input.
- Minimum batch time: 4×22 + 1 (OUTPUT) = 89 cycles from enable rise to error_valid_o.
- enable_i falling in the same cycle as acceptance: the sample is discarded and no strobe is emitted.
- enable_i falling during OUTPUT: the strobe still fires.
- Simultaneous timeout and acceptance (counter reaches STABLE_CYCLES on the last allowed cycle): acceptance wins.

## Test plan
- Constant +3, enable held high: error_valid_o at cycle 89 after enable, error_o=+3, saturated_o=0, then every 89 cycles.
- Per-sample inputs −3, −2, −2, −2: sum −9, error_o=−3 (floor, not −2).
- Input toggling every cycle: timeout_o pulses every 4+16+32 cycles, no error_valid_o, pd_reset_o rises after each timeout.
- One sample of +15 among +1s: error_o=+4 (18>>2), saturated_o=1. Next batch of all +1 gives saturated_o=0.
- enable_i dropped after 2 accepted samples: IDLE next cycle, pd_reset_o=1, busy_o=0. Re-enable yields a full fresh 4-sample batch with no stale contribution.
- reset_i pulsed during OUTPUT: no strobe, all outputs at reset values the cycle after.

Source files
------------

// File: rtl/pd_sample_controller.sv
`default_nettype none
// pd_sample_controller: clear / window / debounced-capture sequencer for the delay-line phase
// detector; averages 2^LOG2_AVG accepted samples into one strobed, signed error word.
module pd_sample_controller #(
  parameter int WIDTH          = 5,
  parameter int RESET_CYCLES   = 4,
  parameter int WINDOW_CYCLES  = 16,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int LOG2_AVG       = 2
) (
  input  logic             fpga_clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] pd_error_i,
  output logic             pd_reset_o,
  output logic [WIDTH-1:0] error_o,
  output logic             error_valid_o,
  output logic             saturated_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > WINDOW_CYCLES)
      ? ((TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES)
      : ((WINDOW_CYCLES > RESET_CYCLES) ? WINDOW_CYCLES : RESET_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int BW = LOG2_AVG + 1;
  localparam int AW = WIDTH + LOG2_AVG;

  localparam logic [CW-1:0] CLEAR_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST     = CW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_TARGET = SW'(STABLE_CYCLES);
  localparam logic [BW-1:0] BATCH_LAST    = BW'((1 << LOG2_AVG) - 1);
  localparam logic signed [WIDTH-1:0] FULL_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] FULL_NEG = -FULL_POS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]        sync_meta, sync_out, sync_prev;
  logic [CW-1:0]           phase_cnt;
  logic [SW-1:0]           stable_cnt, stable_next;
  logic [BW-1:0]           batch_cnt;
  logic signed [AW-1:0]    acc;
  logic                    sat_flag;
  logic                    accept, expire, sample_sat;
  logic signed [WIDTH-1:0] sample;

  assign sample     = sync_out;
  assign sample_sat = (sample == FULL_POS) || (sample <= FULL_NEG);

  always_comb begin
    next_state  = state;
    stable_next = '0;
    accept      = 1'b0;
    expire      = 1'b0;
    if (state == S_CAPTURE) begin
      // A differing bit pattern (including bus skew mid-transition) restarts the run.
      if ((phase_cnt == '0) || (sync_out != sync_prev)) stable_next = SW'(1);
      else                                              stable_next = stable_cnt + SW'(1);
      accept = (stable_next == STABLE_TARGET);
      expire = !accept && (phase_cnt == TIMEOUT_LAST);
    end
    case (state)
      S_IDLE:    if (enable_i) next_state = S_CLEAR;
      S_CLEAR:   if (!enable_i) next_state = S_IDLE;
                 else if (phase_cnt == CLEAR_LAST) next_state = S_WAIT;
      S_WAIT:    if (!enable_i) next_state = S_IDLE;
                 else if (phase_cnt == WAIT_LAST) next_state = S_CAPTURE;
      S_CAPTURE: if (!enable_i) next_state = S_IDLE;
                 else if (accept) next_state = (batch_cnt == BATCH_LAST) ? S_OUTPUT : S_CLEAR;
                 else if (expire) next_state = S_CLEAR;
      S_OUTPUT:  next_state = enable_i ? S_CLEAR : S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      sync_meta     <= '0;
      sync_out      <= '0;
      sync_prev     <= '0;
      state         <= S_IDLE;
      phase_cnt     <= '0;
      stable_cnt    <= '0;
      batch_cnt     <= '0;
      acc           <= '0;
      sat_flag      <= 1'b0;
      pd_reset_o    <= 1'b1;
      busy_o        <= 1'b0;
      error_o       <= '0;
      error_valid_o <= 1'b0;
      saturated_o   <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      sync_meta  <= pd_error_i;
      sync_out   <= sync_meta;
      sync_prev  <= sync_out;
      state      <= next_state;
      stable_cnt <= stable_next;
      if ((next_state != state) || (state == S_IDLE)) phase_cnt <= '0;
      else                                            phase_cnt <= phase_cnt + CW'(1);

      pd_reset_o    <= (next_state == S_IDLE) || (next_state == S_CLEAR);
      busy_o        <= (next_state != S_IDLE);
      timeout_o     <= enable_i && expire;
      error_valid_o <= 1'b0;

      if (state == S_OUTPUT) begin
        error_valid_o <= 1'b1;
        error_o       <= WIDTH'(acc >>> LOG2_AVG);
        saturated_o   <= sat_flag;
      end

      // Holding the batch clear throughout IDLE covers both discard and the fresh start.
      if ((state == S_IDLE) || (state == S_OUTPUT)) begin
        acc       <= '0;
        batch_cnt <= '0;
        sat_flag  <= 1'b0;
      end else if (enable_i && accept) begin
        acc       <= acc + AW'(sample);
        batch_cnt <= batch_cnt + BW'(1);
        sat_flag  <= sat_flag | sample_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pd_sample_controller.sv
`default_nettype none
// Bench for pd_sample_controller: timeline model of the measurement sequence plus directed cases.
module tb_pd_sample_controller;

  localparam int WIDTH          = 5;
  localparam int RESET_CYCLES   = 4;
  localparam int WINDOW_CYCLES  = 16;
  localparam int STABLE_CYCLES  = 2;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int LOG2_AVG       = 2;
  localparam int SAT_LEVEL      = (1 << (WIDTH - 1)) - 1;

  logic             clk = 1'b0;
  logic             reset_i, enable_i;
  logic [WIDTH-1:0] pd_error_i;
  logic             pd_reset_o, error_valid_o, saturated_o, timeout_o, busy_o;
  logic [WIDTH-1:0] error_o;

  int checks = 0;
  int errors = 0;

  pd_sample_controller #(
    .WIDTH(WIDTH), .RESET_CYCLES(RESET_CYCLES), .WINDOW_CYCLES(WINDOW_CYCLES),
    .STABLE_CYCLES(STABLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LOG2_AVG(LOG2_AVG)
  ) dut (
    .fpga_clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .pd_error_i(pd_error_i),
    .pd_reset_o(pd_reset_o), .error_o(error_o), .error_valid_o(error_valid_o),
    .saturated_o(saturated_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: one timeline per measurement ----------------
  logic             m_pd_reset = 1'b1, m_busy = 1'b0, m_valid = 1'b0, m_sat = 1'b0, m_to = 1'b0;
  logic [WIDTH-1:0] m_err = '0;
  bit               t_rst, t_en;
  // Last four sampled inputs; entry [1] is what the comparator sees, [0] the cycle before.
  int               hist[$] = '{0, 0, 0, 0};

  task automatic tick();
    @(posedge clk);
    t_rst   = reset_i;
    t_en    = enable_i;
    m_valid = 1'b0;
    m_to    = 1'b0;
    if (t_rst) begin
      hist       = '{0, 0, 0, 0};
      m_pd_reset = 1'b1;
      m_busy     = 1'b0;
      m_err      = '0;
      m_sat      = 1'b0;
    end else begin
      hist.push_back(int'($signed(pd_error_i)));
      void'(hist.pop_front());
    end
  endtask

  function automatic bit aborted();
    if (t_rst) return 1'b1;
    if (!t_en) begin
      m_pd_reset = 1'b1;
      m_busy     = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_batches();
    int acc = 0, n = 0, run = 0, v = 0;
    bit satf = 1'b0, got;
    forever begin
      for (int i = 0; i < RESET_CYCLES; i++) begin
        tick();
        if (aborted()) return;
        m_pd_reset = (i < RESET_CYCLES - 1);
      end
      for (int i = 0; i < WINDOW_CYCLES; i++) begin
        tick();
        if (aborted()) return;
      end
      got = 1'b0;
      for (int i = 0; i < TIMEOUT_CYCLES && !got; i++) begin
        tick();
        if (aborted()) return;
        run = (i == 0 || hist[1] != hist[0]) ? 1 : run + 1;
        if (run >= STABLE_CYCLES) begin
          got = 1'b1;
          v   = hist[1];
        end
      end
      m_pd_reset = 1'b1;
      if (!got) begin
        m_to = 1'b1;
        continue;
      end
      acc += v;
      n++;
      if (v >= SAT_LEVEL || v <= -SAT_LEVEL) satf = 1'b1;
      if (n < (1 << LOG2_AVG)) continue;
      m_pd_reset = 1'b0;
      tick();
      if (t_rst) return;
      m_valid = 1'b1;
      m_err   = WIDTH'(acc >>> LOG2_AVG);
      m_sat   = satf;
      acc = 0; n = 0; satf = 1'b0;
      if (!t_en) begin
        m_pd_reset = 1'b1;
        m_busy     = 1'b0;
        return;
      end
      m_pd_reset = 1'b1;
    end
  endtask

  initial begin : model
    forever begin
      tick();
      if (!t_rst && t_en) begin
        m_pd_reset = 1'b1;
        m_busy     = 1'b1;
        run_batches();
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      check("pd_reset_o", int'(pd_reset_o), int'(m_pd_reset));
      check("busy_o", int'(busy_o), int'(m_busy));
      check("error_valid_o", int'(error_valid_o), int'(m_valid));
      check("timeout_o", int'(timeout_o), int'(m_to));
      check("saturated_o", int'(saturated_o), int'(m_sat));
      check("error_o", int'($signed(error_o)), int'($signed(m_err)));
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pd(input int v);
    pd_error_i = WIDTH'(v);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!error_valid_o && n < 400);
    if (!error_valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: error_valid_o still 0 after %0d cycles, expected a strobe", name, n);
    end
  endtask

  task automatic wait_rise(input string name);
    int  n = 0;
    bit  prev = pd_reset_o;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (pd_reset_o && !prev) return;
      prev = pd_reset_o;
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL %s: pd_reset_o no rise after %0d cycles, expected one", name, n);
        return;
      end
    end
  endtask

  // Start from IDLE, feed one value per sample (changed while the detector is held clear).
  task automatic run_batch(input string name, input int a, input int b, input int c, input int d,
                           output int n);
    enable_i = 1'b0;
    go(2);
    set_pd(a);
    enable_i = 1'b1;
    go(1);
    wait_rise(name); set_pd(b);
    wait_rise(name); set_pd(c);
    wait_rise(name); set_pd(d);
    wait_valid(name, n);
  endtask

  initial begin : stimulus
    int n, first, last;
    int hold;
    reset_i = 1'b1; enable_i = 1'b0; pd_error_i = '0;
    go(3);
    reset_i = 1'b0;
    check("reset_pd_reset", int'(pd_reset_o), 1);
    check("reset_busy", int'(busy_o), 0);
    check("reset_error", int'(error_o), 0);
    check("reset_valid", int'(error_valid_o), 0);

    // Constant +3: first strobe 89 cycles after enable is sampled, then every 89.
    set_pd(3); enable_i = 1'b1; go(1);
    wait_valid("const3_first", n);
    check("const3_latency", n, 89);
    check("const3_error", int'($signed(error_o)), 3);
    check("const3_model_error", int'($signed(m_err)), 3);
    check("const3_sat", int'(saturated_o), 0);
    wait_valid("const3_second", n);
    check("const3_period", n, 89);

    run_batch("floor", -3, -2, -2, -2, n);
    check("floor_error", int'($signed(error_o)), -3);
    check("floor_model_error", int'($signed(m_err)), -3);

    run_batch("sat15", 1, 15, 1, 1, n);
    check("sat15_error", int'($signed(error_o)), 4);
    check("sat15_sat", int'(saturated_o), 1);
    wait_valid("sat_clear", n);
    check("sat_clear_error", int'($signed(error_o)), 1);
    check("sat_clear_sat", int'(saturated_o), 0);

    run_batch("neg16", -16, -16, -16, -16, n);
    check("neg16_error", int'($signed(error_o)), -16);
    check("neg16_sat", int'(saturated_o), 1);
    run_batch("neg15", 0, -15, 0, 0, n);
    check("neg15_error", int'($signed(error_o)), -4);
    check("neg15_sat", int'(saturated_o), 1);
    run_batch("pos14", 14, 14, 14, 14, n);
    check("pos14_error", int'($signed(error_o)), 14);
    check("pos14_sat", int'(saturated_o), 0);

    // Toggling input never settles: timeout every 4+16+32 cycles.
    enable_i = 1'b0; go(2);
    set_pd(3); enable_i = 1'b1; go(1);
    first = 0; last = 0;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk);
      #1;
      pd_error_i = (pd_error_i == WIDTH'(3)) ? WIDTH'(4) : WIDTH'(3);
      if (timeout_o) begin
        check("toggle_pd_reset_after_timeout", int'(pd_reset_o), 1);
        if (first == 0) first = c;
        else if (last == 0) last = c;
      end
    end
    check("toggle_first_timeout", first, 52);
    check("toggle_timeout_period", last - first, 52);

    // Drop enable after two accepted samples, then a fresh batch.
    enable_i = 1'b0; go(2);
    set_pd(5); enable_i = 1'b1; go(1);
    wait_rise("drop_s1");
    wait_rise("drop_s2");
    go(5);
    enable_i = 1'b0;
    go(1);
    check("drop_pd_reset", int'(pd_reset_o), 1);
    check("drop_busy", int'(busy_o), 0);
    set_pd(7); enable_i = 1'b1; go(1);
    wait_valid("fresh", n);
    check("fresh_latency", n, 89);
    check("fresh_error", int'($signed(error_o)), 7);

    // Reset on the cycle leaving OUTPUT suppresses the strobe.
    enable_i = 1'b0; go(2);
    set_pd(2); enable_i = 1'b1; go(1);
    go(88);
    check("output_busy", int'(busy_o), 1);
    reset_i = 1'b1;
    go(1);
    reset_i = 1'b0; enable_i = 1'b0;
    check("rst_out_valid", int'(error_valid_o), 0);
    check("rst_out_error", int'(error_o), 0);
    check("rst_out_pd_reset", int'(pd_reset_o), 1);
    check("rst_out_busy", int'(busy_o), 0);

    // Randomised run against the model.
    hold = 0;
    enable_i = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      @(posedge clk);
      #1;
      reset_i = ($urandom_range(0, 2999) == 0);
      if (enable_i) begin
        if ($urandom_range(0, 999) == 0) enable_i = 1'b0;
      end else if ($urandom_range(0, 9) < 3) begin
        enable_i = 1'b1;
      end
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0:       set_pd(SAT_LEVEL);
          1:       set_pd(-SAT_LEVEL - 1);
          2:       set_pd(-SAT_LEVEL);
          default: pd_error_i = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        endcase
        hold = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 60));
      end else begin
        hold--;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
